sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Serial-to-parallel frame receiver that sits directly downstream of the team's PISO shift stage. It consumes the LSB-first serial bit stream, strips start/parity/stop framing, and reassembles WIDTH-bit words. Good words go into a 2-entry output FIFO with a valid/ready handshake. Framing, parity and overrun faults are reported as single-cycle pulses.

## Interface
- WIDTH, default 4: data bits per frame.
- PARITY, default 1: 1 = one even-parity bit follows the data; 0 = no parity bit.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; serial_in is sampled only on cycles where bit_en=1.
- serial_in  input  1  serial line; idles at 0.
- data_out  output  WIDTH  word at the FIFO head.
- out_valid  output  1  FIFO non-empty; data_out is valid.
- out_ready  input  1  consumer accepts the head word when out_valid=1 and out_ready=1.
- busy  output  1  FSM is not in IDLE.
- parity_err  output  1  one-cycle pulse: a frame was dropped for bad parity.
- frame_err  output  1  one-cycle pulse: a frame was dropped for a bad stop bit.
- overrun  output  1  one-cycle pulse: a good frame was dropped because the FIFO was full.

## Operation
- Frame format on the line: start bit (1), then WIDTH data bits LSB first, then a parity bit if PARITY=1, then a stop bit (0). The line idles at 0.
- FSM states: IDLE, DATA, PAR, STOP. Transitions occur only on bit_en cycles.
  - IDLE: serial_in=1 moves to DATA, clears the bit counter, and clears the shift register.
  - DATA: each bit shifts into the MSB of the shift register, so after WIDTH bits bit 0 holds the first data bit. When the counter reaches WIDTH-1, go to PAR if PARITY=1, else to STOP.
  - PAR: capture the parity bit. Go to STOP.
  - STOP: evaluate the frame, then return to IDLE.
- Frame evaluation on the STOP sample:
  - Good frame: stop bit = 0 and, if PARITY=1, the XOR of the data and parity bits = 0. The word is pushed into the FIFO.
  - Stop bit = 1: frame_err pulses and the word is discarded. That 1 is not treated as a new start bit.
  - Parity mismatch: parity_err pulses and the word is discarded.
  - Both faults on one frame: both pulses assert together.
  - Good frame while the FIFO is full and no pop occurs that cycle: overrun pulses and the word is discarded.
- FIFO, 2 entries:
  - Push succeeds if count<2, or if count=2 and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged and preserves order.
  - Pop with count=0 is impossible, because out_valid=0.
- data_out shows the head entry whenever out_valid=1, and is held stable while out_ready=0.
- busy = 1 in DATA, PAR and STOP.
- Cycles with bit_en=0 freeze the FSM, the counter and the shift register. The FIFO handshake still operates on those cycles.

## Timing
- Reset values:
  - FSM = IDLE; counter, shift register and FIFO cleared.
  - data_out = 0, out_valid = 0, busy = 0.
  - parity_err = 0, frame_err = 0, overrun = 0.
- Reset mid-frame abandons the frame and empties the FIFO. No error pulse is generated.
- Latency:
  - The push happens at the clock edge that samples the stop bit. out_valid=1 and data_out are valid from the next cycle.
  - Error pulses assert in the cycle after the stop-bit sample and last exactly one cycle.
- busy rises in the cycle after the start-bit sample. It falls in the cycle after the stop-bit sample.
- With continuous bit_en, back-to-back frames are allowed: a start bit may be sampled in the very next bit_en cycle after a stop bit.
- Maximum throughput is one word per WIDTH+2+PARITY bit_en cycles. With out_ready held at 1, the FIFO never overruns.

## Test plan
- Basic frame (WIDTH=4, PARITY=1, bit_en=1, out_ready=1): send 1, 0,1,0,1, 0, 0 → data_out=0xA with out_valid=1 for exactly one cycle, the cycle after the stop sample; no error pulses.
- Parity fault: send 1, 1,0,0,0, 0, 0 (parity should be 1) → parity_err pulses once; out_valid stays 0; FSM returns to IDLE.
- Framing fault: send 0x5 with correct parity, then stop bit = 1, then line = 0 → frame_err pulses once; no new frame is started; busy=0.
- Backpressure: out_ready=0, send 0x3, 0xC, 0x7 back-to-back → 0x3 and 0xC are held, with data_out=0x3; overrun pulses on the third frame. Then raise out_ready → 0x3 then 0xC are delivered and out_valid drops.
- Full FIFO with pop: count=2 and out_ready=1 in the cycle the 0x9 stop bit is sampled → 0x9 is accepted with no overrun; the output order is preserved.
- Reset mid-frame plus throttled bit_en: bit_en=1 every 3rd cycle, assert reset after 2 data bits → all outputs return to reset values. A subsequent clean 0xF frame is received correctly.

Source files
------------

// File: rtl/sipo_frame_rx_if.sv
// rtl/sipo_frame_rx_if.sv - output word stream between the frame receiver and its consumer
//   data_out   word at the receiver FIFO head (valid only while out_valid=1)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head word when out_valid=1
//   master: receiver side; slave: consumer side
interface sipo_frame_rx_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - LSB-first serial frame receiver with 2-entry output FIFO
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   bit_en      bit strobe; serial_in sampled only when 1
//   serial_in   serial line, idles at 0
//   out         word stream (data_out/out_valid/out_ready), master side
//   busy        FSM outside IDLE
//   parity_err  one-cycle pulse: frame dropped for bad parity
//   frame_err   one-cycle pulse: frame dropped for bad stop bit
//   overrun     one-cycle pulse: good frame dropped, FIFO full
module sipo_frame_rx #(
  parameter int WIDTH  = 4,
  parameter int PARITY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              serial_in,
  sipo_frame_rx_if.master   out,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_shift;
  logic             par_bit;

  logic             do_start, do_shift, do_par, do_eval;
  logic             stop_bad, par_bad, good;

  logic [WIDTH-1:0] mem [0:1];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             pop, push, drop;

  // Each new bit enters at the MSB, so the first data bit ends up in bit 0.
  always_comb begin
    sh_shift = '0;
    for (int i = 0; i < WIDTH - 1; i++) sh_shift[i] = shreg[i+1];
    sh_shift[WIDTH-1] = serial_in;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_shift = 1'b0;
    do_par   = 1'b0;
    do_eval  = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (serial_in) begin
            do_start = 1'b1;
            state_n  = DATA;
          end
        end
        DATA: begin
          do_shift = 1'b1;
          if (cnt == CW'(WIDTH - 1)) state_n = (PARITY != 0) ? PAR : STOP;
        end
        PAR: begin
          do_par  = 1'b1;
          state_n = STOP;
        end
        STOP: begin
          // A 1 here is a bad stop bit, never a fresh start bit.
          do_eval = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (do_start) begin
        cnt   <= '0;
        shreg <= '0;
      end
      if (do_shift) begin
        shreg <= sh_shift;
        cnt   <= cnt + CW'(1);
      end
      if (do_par) par_bit <= serial_in;
    end
  end

  // Frame evaluation on the stop sample; even parity covers data plus parity bit.
  assign stop_bad = do_eval & serial_in;
  assign par_bad  = do_eval & (PARITY != 0) & ((^shreg) ^ par_bit);
  assign good     = do_eval & ~serial_in & ~par_bad;

  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign pop  = (count != 2'd0) & out.out_ready;
  assign push = good & ((count != 2'd2) | pop);
  assign drop = good & (count == 2'd2) & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out.out_valid = (count != 2'd0);
  assign out.data_out  = out.out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= par_bad;
      frame_err  <= stop_bad;
      overrun    <= drop;
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - directed bench for sipo_frame_rx (WIDTH=4, PARITY=1)
module tb_sipo_frame_rx;

  logic clk = 1'b0;
  logic reset;
  logic bit_en;
  logic serial_in;
  logic busy, parity_err, frame_err, overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sipo_frame_rx_if #(.WIDTH(4)) bus ();

  sipo_frame_rx #(.WIDTH(4), .PARITY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .out        (bus),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    bit_en    = 1'b1;
    tick();
    bit_en    = 1'b0;
    serial_in = 1'b0;
  endtask

  // bit_en high only every third cycle
  task automatic send_bit_slow(input logic b);
    bit_en = 1'b0;
    tick();
    tick();
    send_bit(b);
  endtask

  task automatic send_head(input logic [3:0] w, input logic p);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
    send_bit(p);
  endtask

  task automatic send_frame(input logic [3:0] w, input logic p, input logic stopb);
    send_head(w, p);
    send_bit(stopb);
  endtask

  initial begin
    reset         = 1'b1;
    bit_en        = 1'b0;
    serial_in     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data",  bus.data_out,  0);
    check("rst_busy",  busy,          0);
    check("rst_perr",  parity_err,    0);
    check("rst_ferr",  frame_err,     0);
    check("rst_ovr",   overrun,       0);
    reset = 1'b0;
    tick();

    // Basic frame 0xA, parity 0
    send_bit(1'b1);
    check("basic_busy_rise", busy, 1);
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    send_bit(0);
    check("basic_valid_early", bus.out_valid, 0);
    send_bit(0);
    check("basic_valid", bus.out_valid, 1);
    check("basic_data",  bus.data_out,  4'hA);
    check("basic_busy_fall", busy, 0);
    check("basic_noerr", {parity_err, frame_err, overrun}, 0);
    tick();
    check("basic_valid_one_cycle", bus.out_valid, 0);

    // Parity fault: 0x1 with parity 0
    send_frame(4'h1, 1'b0, 1'b0);
    check("par_perr",  parity_err, 1);
    check("par_ferr",  frame_err,  0);
    check("par_valid", bus.out_valid, 0);
    check("par_busy",  busy, 0);
    tick();
    check("par_perr_pulse", parity_err, 0);

    // Framing fault: 0x5, parity 0, stop 1, then line 0
    send_frame(4'h5, 1'b0, 1'b1);
    check("frm_ferr",  frame_err,  1);
    check("frm_perr",  parity_err, 0);
    check("frm_valid", bus.out_valid, 0);
    send_bit(1'b0);
    check("frm_ferr_pulse", frame_err, 0);
    check("frm_no_restart", busy, 0);

    // Backpressure: 0x3, 0xC, 0x7 with out_ready low
    bus.out_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b0);
    check("bp_first_valid", bus.out_valid, 1);
    check("bp_first_data",  bus.data_out,  4'h3);
    send_frame(4'hC, 1'b0, 1'b0);
    check("bp_second_data", bus.data_out,  4'h3);
    check("bp_second_ovr",  overrun, 0);
    send_frame(4'h7, 1'b1, 1'b0);
    check("bp_ovr",         overrun, 1);
    check("bp_hold_data",   bus.data_out, 4'h3);
    tick();
    check("bp_ovr_pulse",   overrun, 0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1_valid",  bus.out_valid, 1);
    check("bp_pop1_data",   bus.data_out,  4'hC);
    tick();
    check("bp_empty",       bus.out_valid, 0);

    // Full FIFO with pop on the stop sample: 0x1, 0x2 queued, then 0x9
    bus.out_ready = 1'b0;
    send_frame(4'h1, 1'b1, 1'b0);
    send_frame(4'h2, 1'b1, 1'b0);
    send_head(4'h9, 1'b0);
    check("pop_full_head", bus.data_out, 4'h1);
    bus.out_ready = 1'b1;
    send_bit(1'b0);
    check("pop_no_ovr", overrun, 0);
    check("pop_head2",  bus.data_out, 4'h2);
    tick();
    check("pop_head9",  bus.data_out, 4'h9);
    check("pop_valid9", bus.out_valid, 1);
    tick();
    check("pop_empty",  bus.out_valid, 0);

    // Reset mid-frame with throttled strobe
    bus.out_ready = 1'b0;
    send_frame(4'h6, 1'b0, 1'b0);
    check("mid_pre_valid", bus.out_valid, 1);
    send_bit_slow(1'b1);
    send_bit_slow(1'b0);
    send_bit_slow(1'b1);
    bit_en = 1'b0;
    tick();
    check("mid_busy_frozen", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data",  bus.data_out,  0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_errs",  {parity_err, frame_err, overrun}, 0);
    tick();
    check("mid_rst_noerr_after", {parity_err, frame_err, overrun}, 0);
    bus.out_ready = 1'b1;
    send_bit_slow(1'b1);
    send_bit_slow(1'b1);
    send_bit_slow(1'b1);
    send_bit_slow(1'b1);
    send_bit_slow(1'b1);
    send_bit_slow(1'b0);
    send_bit_slow(1'b0);
    check("clean_valid", bus.out_valid, 1);
    check("clean_data",  bus.data_out,  4'hF);
    check("clean_errs",  {parity_err, frame_err, overrun}, 0);
    tick();
    check("clean_drained", bus.out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
